// File: rtl/pwr_button_reader_pkg.sv
// rtl/pwr_button_reader_pkg.sv - event word layout and FSM encodings for the power button reader
package pwr_button_reader_pkg;

  localparam int EVT_W       = 24;
  localparam int EVT_OVF     = 23;
  localparam int EVT_REL     = 22;
  localparam int EVT_SEQ_LSB = 16;
  localparam int EVT_SEQ_W   = 6;
  localparam int EVT_DUR_W   = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  // ovf is left clear here; it is merged in at FIFO-write time
  function automatic logic [EVT_W-1:0] make_evt(input logic                 rel,
                                                 input logic [EVT_SEQ_W-1:0] seq,
                                                 input logic [EVT_DUR_W-1:0] dur);
    logic [EVT_W-1:0] w;
    w                            = '0;
    w[EVT_REL]                   = rel;
    w[EVT_SEQ_LSB +: EVT_SEQ_W]  = seq;
    w[EVT_DUR_W-1:0]             = dur;
    return w;
  endfunction

endpackage

// File: rtl/pwr_button_reader_fifo.sv
// rtl/pwr_button_reader_fifo.sv - show-ahead event FIFO; a push into a full FIFO is taken only alongside a pop
module pwr_button_reader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             accept
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_pop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign accept = push && (!full || do_pop);
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !do_pop)      count <= count + 1'b1;
      else if (!accept && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pwr_button_reader.sv
// rtl/pwr_button_reader.sv - debounces the power button, times presses in ticks and queues press/release events
module pwr_button_reader
  import pwr_button_reader_pkg::*;
#(
  parameter int TICK_DIV   = 5000000,
  parameter int DEBOUNCE   = 50000,
  parameter int FIFO_DEPTH = 4,
  parameter int LONG_TICKS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_n,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_rd,
  output logic        long_press
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int TK_W = $clog2(TICK_DIV + 1);

  logic                 sync1, sync2, stable;
  logic [DB_W-1:0]      db_cnt;
  logic [TK_W-1:0]      tick_cnt;
  logic                 stb;
  state_t               state, state_nxt;
  logic [EVT_DUR_W-1:0] dur;
  logic [EVT_SEQ_W-1:0] seq;
  logic                 ovf;
  logic                 push_c, push_q, dur_inc, lp_c;
  logic [EVT_W-1:0]     evt_c, evt_q, fifo_wdata;
  logic                 fifo_empty, fifo_accept;

  // stable is active-low like btn_n: 1 = released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign stb = (tick_cnt == TK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      tick_cnt <= '0;
    else if (stb) tick_cnt <= '0;
    else          tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (!stable) state_nxt = ST_PRESSED;
      ST_PRESSED: if (stable)  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // a tick landing on the release cycle is dropped so the event carries the settled duration
  always_comb begin
    push_c  = 1'b0;
    evt_c   = '0;
    dur_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!stable) begin
          push_c = 1'b1;
          evt_c  = make_evt(1'b0, seq, 16'd0);
        end
      end
      ST_PRESSED: begin
        if (stable) begin
          push_c = 1'b1;
          evt_c  = make_evt(1'b1, seq, dur);
        end else if (stb && dur != 16'hFFFF) begin
          dur_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign lp_c = dur_inc && ((dur + 16'd1) == 16'(LONG_TICKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur        <= '0;
      seq        <= '0;
      push_q     <= 1'b0;
      evt_q      <= '0;
      long_press <= 1'b0;
    end else begin
      push_q     <= push_c;
      evt_q      <= evt_c;
      long_press <= lp_c;
      if (push_c) seq <= seq + 1'b1;
      if (push_c && state == ST_IDLE) dur <= '0;
      else if (dur_inc)               dur <= dur + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     ovf <= 1'b0;
    else if (fifo_accept)        ovf <= 1'b0;
    else if (push_q)             ovf <= 1'b1;
  end

  always_comb begin
    fifo_wdata          = evt_q;
    fifo_wdata[EVT_OVF] = ovf;
  end

  pwr_button_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_q),
    .pop    (out_rd),
    .wdata  (fifo_wdata),
    .head   (out_data),
    .empty  (fifo_empty),
    .accept (fifo_accept)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_pwr_button_reader.sv
// tb/tb_pwr_button_reader.sv - directed bench for pwr_button_reader with small tick/debounce values
module tb_pwr_button_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_n;
  logic        out_rd;
  logic [23:0] out_data;
  logic        out_valid;
  logic        long_press;

  int vectors     = 0;
  int miscompares = 0;
  int lp_total    = 0;

  pwr_button_reader #(
    .TICK_DIV   (10),
    .DEBOUNCE   (4),
    .FIFO_DEPTH (4),
    .LONG_TICKS (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_rd     (out_rd),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (long_press) lp_total++;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; btn_n = 1'b1; out_rd = 1'b0;
    wait_neg(3);
    rst = 1'b0;
    wait_neg(2);
  endtask

  task automatic do_press(input int low_cycles, input int high_cycles);
    btn_n = 1'b0;
    wait_neg(low_cycles);
    btn_n = 1'b1;
    wait_neg(high_cycles);
  endtask

  task automatic pop();
    out_rd = 1'b1;
    wait_neg(1);
    out_rd = 1'b0;
  endtask

  task automatic drain(input string name, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_hi [4];
    exp_hi = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data[23:16] !== exp_hi[i]) begin
        miscompares++;
        $display("FAIL %s[%0d]: valid=%b hi=%h, expected valid=1 hi=%h", name, i, out_valid, out_data[23:16], exp_hi[i]);
      end
      if (exp_hi[i][6] == 1'b0) begin
        vectors++;
        if (out_data[15:0] !== 16'h0000) begin
          miscompares++;
          $display("FAIL %s[%0d]_dur: got %h expected 0000", name, i, out_data[15:0]);
        end
      end
      pop();
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_empty: out_valid=%b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_n = 1'b1; out_rd = 1'b0;
    wait_neg(2);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 24'h0 || long_press !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: valid=%b data=%h lp=%b expected 0/000000/0", out_valid, out_data, long_press);
    end
    rst = 1'b0;
    wait_neg(2);
  endtask

  task automatic test_glitch();
    int lp0;
    logic seen;
    lp0  = lp_total;
    seen = 1'b0;
    btn_n = 1'b0;
    wait_neg(3);
    btn_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wait_neg(1);
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || lp_total != lp0) begin
      miscompares++;
      $display("FAIL glitch: valid_seen=%b long_press_pulses=%0d expected 0/0", seen, lp_total - lp0);
    end
  endtask

  task automatic test_short_press();
    btn_n = 1'b0;
    wait_neg(7);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL press_latency_early: out_valid=%b expected 0", out_valid);
    end
    wait_neg(1);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 24'h000000) begin
      miscompares++;
      $display("FAIL press_event: valid=%b data=%h expected 1/000000", out_valid, out_data);
    end
    pop();
    wait_neg(16);
    btn_n = 1'b1;
    wait_neg(7);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL release_latency_early: out_valid=%b expected 0", out_valid);
    end
    wait_neg(1);
    vectors++;
    if (out_valid !== 1'b1 || out_data[23:16] !== 8'h41 ||
        !(out_data[15:0] == 16'd2 || out_data[15:0] == 16'd3)) begin
      miscompares++;
      $display("FAIL release_event: valid=%b data=%h expected 1/41000{2,3}", out_valid, out_data);
    end
    pop();
  endtask

  task automatic test_long_press();
    int lp0;
    lp0 = lp_total;
    btn_n = 1'b0;
    wait_neg(8);
    vectors++;
    if (out_data !== 24'h020000) begin
      miscompares++;
      $display("FAIL long_press_event: got %h expected 020000", out_data);
    end
    pop();
    wait_neg(36);
    btn_n = 1'b1;
    wait_neg(8);
    vectors++;
    if (out_data[23:16] !== 8'h43 || out_data[15:0] < 16'd3) begin
      miscompares++;
      $display("FAIL long_release_event: got %h expected 43 with dur>=3", out_data);
    end
    vectors++;
    if (lp_total - lp0 != 1) begin
      miscompares++;
      $display("FAIL long_press_pulses: got %0d expected 1", lp_total - lp0);
    end
    pop();
  endtask

  task automatic test_overflow();
    apply_reset();
    do_press(12, 12);
    do_press(12, 12);
    do_press(12, 12);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 24'h000000) begin
      miscompares++;
      $display("FAIL ovf_head: valid=%b data=%h expected 1/000000", out_valid, out_data);
    end
    pop();
    vectors++;
    if (out_data[23:16] !== 8'h41) begin
      miscompares++;
      $display("FAIL ovf_head_after_pop: hi=%h expected 41", out_data[23:16]);
    end
    btn_n = 1'b0;
    wait_neg(8);
    pop();
    btn_n = 1'b1;
    wait_neg(10);
    drain("ovf_drain", 8'h02, 8'h43, 8'h86, 8'h47);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_press(12, 12);
    do_press(12, 12);
    btn_n = 1'b0;
    wait_neg(7);
    out_rd = 1'b1;
    wait_neg(1);
    out_rd = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data[23:16] !== 8'h41) begin
      miscompares++;
      $display("FAIL full_push_pop_head: valid=%b hi=%h expected 1/41", out_valid, out_data[23:16]);
    end
    drain("full_push_pop_drain", 8'h41, 8'h02, 8'h43, 8'h04);
    btn_n = 1'b1;
    wait_neg(8);
    vectors++;
    if (out_valid !== 1'b1 || out_data[23:16] !== 8'h45) begin
      miscompares++;
      $display("FAIL release_seq5: valid=%b hi=%h expected 1/45", out_valid, out_data[23:16]);
    end
    pop();
    out_rd = 1'b1;
    wait_neg(3);
    out_rd = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_rd: out_valid=%b expected 0", out_valid);
    end
    btn_n = 1'b0;
    wait_neg(7);
    out_rd = 1'b1;
    wait_neg(1);
    out_rd = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 24'h060000) begin
      miscompares++;
      $display("FAIL empty_push_pop: valid=%b data=%h expected 1/060000", out_valid, out_data);
    end
    pop();
    btn_n = 1'b1;
    wait_neg(10);
    vectors++;
    if (out_valid !== 1'b1 || out_data[23:16] !== 8'h47) begin
      miscompares++;
      $display("FAIL release_seq7: valid=%b hi=%h expected 1/47", out_valid, out_data[23:16]);
    end
    pop();
  endtask

  task automatic test_reset_mid_press();
    btn_n = 1'b0;
    wait_neg(8);
    vectors++;
    if (out_data !== 24'h080000) begin
      miscompares++;
      $display("FAIL pre_reset_event: got %h expected 080000", out_data);
    end
    wait_neg(5);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 24'h0 || long_press !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_immediate: valid=%b data=%h lp=%b expected 0/000000/0", out_valid, out_data, long_press);
    end
    @(negedge clk);
    wait_neg(2);
    rst = 1'b0;
    wait_neg(7);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_early: out_valid=%b expected 0", out_valid);
    end
    wait_neg(1);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 24'h000000) begin
      miscompares++;
      $display("FAIL post_reset_press: valid=%b data=%h expected 1/000000", out_valid, out_data);
    end
    pop();
    wait_neg(10);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_single: out_valid=%b expected 0", out_valid);
    end
    btn_n = 1'b1;
    wait_neg(10);
  endtask

  initial begin
    rst = 1'b1; btn_n = 1'b1; out_rd = 1'b0;
    test_reset();
    test_glitch();
    test_short_press();
    test_long_press();
    test_overflow();
    test_back_to_back();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
